itype_commit_checker: RTL

Synthesizable scoreboard for the Sodor 5-stage I-type verification flow. It sits on the consumer side of the imem instruction stream: it captures each I-type instruction handed to the core and computes its expected result against a shadow register file. It then checks every register writeback the core commits against that expected result, in program order, and reports pass/mismatch counts.

---
 rtl/itc_pkg.sv | 32 +++
 rtl/itc_fifo.sv | 49 ++++
 rtl/itype_commit_checker.sv | 136 +++++++++++++
 3 files changed

// File: rtl/itc_pkg.sv
// Shared types for the I-type commit checker: opcode, funct3 encoding,
// queued instruction entry and error codes.
package itc_pkg;

    localparam logic [6:0] OPC_OP_IMM = 7'b0010011;

    typedef enum logic [2:0] {
        F3_ADDI  = 3'd0,
        F3_SLLI  = 3'd1,
        F3_SLTI  = 3'd2,
        F3_SLTIU = 3'd3,
        F3_XORI  = 3'd4,
        F3_SRXI  = 3'd5,
        F3_ORI   = 3'd6,
        F3_ANDI  = 3'd7
    } funct3_t;

    typedef struct packed {
        logic [4:0]  rd;
        logic [4:0]  rs1;
        funct3_t     funct3;
        logic [11:0] imm;
    } itc_entry_t;

    typedef enum logic [1:0] {
        ERR_NONE      = 2'd0,
        ERR_DATA      = 2'd1,
        ERR_RD        = 2'd2,
        ERR_UNDERFLOW = 2'd3
    } err_code_t;

endpackage

// File: rtl/itc_fifo.sv
// In-flight instruction queue: synchronous FIFO of itc_entry_t using
// wrap-around pointers with one extra bit to tell full from empty.
module itc_fifo
    import itc_pkg::*;
#(
    parameter int DEPTH = 8
) (
    input  logic                   clk,
    input  logic                   reset_n,
    input  logic                   i_push,
    input  itc_entry_t             i_pushData,
    input  logic                   i_pop,
    output itc_entry_t             o_head,
    output logic                   o_full,
    output logic                   o_empty,
    output logic [$clog2(DEPTH):0] o_count
);

    localparam int AW = $clog2(DEPTH);

    itc_entry_t      r_mem [DEPTH];
    logic [AW:0]     r_wptr;
    logic [AW:0]     r_rptr;
    logic            w_doPush;
    logic            w_doPop;

    assign o_count  = r_wptr - r_rptr;
    assign o_full   = (o_count == (AW+1)'(DEPTH));
    assign o_empty  = (r_wptr == r_rptr);
    assign o_head   = r_mem[r_rptr[AW-1:0]];
    assign w_doPush = i_push && !o_full;
    assign w_doPop  = i_pop && !o_empty;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_wptr <= '0;
            r_rptr <= '0;
        end else begin
            if (w_doPush) r_wptr <= r_wptr + 1'b1;
            if (w_doPop)  r_rptr <= r_rptr + 1'b1;
        end
    end

    // Storage is not reset; only the pointers define which entries are live.
    always_ff @(posedge clk) begin
        if (w_doPush) r_mem[r_wptr[AW-1:0]] <= i_pushData;
    end

endmodule

// File: rtl/itype_commit_checker.sv
// I-type commit scoreboard: queues OP-IMM instructions, predicts results from a
// shadow regfile and checks core writebacks in order. ITC_STICKY_ERR_EN latches the first error.
module itype_commit_checker
    import itc_pkg::*;
#(
    parameter int DEPTH = 8,
    parameter int XLEN  = 32
) (
    input  logic                   clk,
    input  logic                   reset_n,
    input  logic                   in_valid,
    input  logic [31:0]            in_instr,
    output logic                   in_ready,
    input  logic                   init_we,
    input  logic [4:0]             init_addr,
    input  logic [XLEN-1:0]        init_data,
    input  logic                   wb_valid,
    input  logic [4:0]             wb_rd,
    input  logic [XLEN-1:0]        wb_data,
    output logic                   mismatch,
    output logic [1:0]             err_code,
    output logic [31:0]            pass_cnt,
    output logic [31:0]            err_cnt,
    output logic [$clog2(DEPTH):0] occupancy
);

    logic [XLEN-1:0] r_shadow [32];
    logic            r_mismatch;
    err_code_t       r_errCode;
    logic [31:0]     r_passCnt;
    logic [31:0]     r_errCnt;

    itc_entry_t      w_newEntry;
    itc_entry_t      w_head;
    logic            w_full;
    logic            w_empty;
    logic            w_enq;
    logic            w_commit;
    logic            w_pop;
    logic [XLEN-1:0] w_rs1Val;
    logic [XLEN-1:0] w_expected;
    err_code_t       w_errCode;

    function automatic logic [XLEN-1:0] aluResult(input itc_entry_t e, input logic [XLEN-1:0] a);
        logic [XLEN-1:0] b;
        logic [4:0]      sh;
        logic [XLEN-1:0] r;
        b  = {{(XLEN-12){e.imm[11]}}, e.imm};
        sh = e.imm[4:0];
        case (e.funct3)
            F3_ADDI:  r = a + b;
            F3_SLLI:  r = a << sh;
            F3_SLTI:  r = {{(XLEN-1){1'b0}}, ($signed(a) < $signed(b))};
            F3_SLTIU: r = {{(XLEN-1){1'b0}}, (a < b)};
            F3_XORI:  r = a ^ b;
            F3_SRXI:  r = e.imm[10] ? XLEN'($signed(a) >>> sh) : (a >> sh);
            F3_ORI:   r = a | b;
            F3_ANDI:  r = a & b;
            default:  r = '0;
        endcase
        return r;
    endfunction

    assign w_newEntry = '{rd:     in_instr[11:7],
                          rs1:    in_instr[19:15],
                          funct3: funct3_t'(in_instr[14:12]),
                          imm:    in_instr[31:20]};

    assign in_ready   = !w_full;
    assign w_enq      = in_valid && in_ready && (in_instr[6:0] == OPC_OP_IMM) && (in_instr[11:7] != 5'd0);
    assign w_commit   = wb_valid && (wb_rd != 5'd0);
    assign w_pop      = w_commit && !w_empty;
    assign w_rs1Val   = (w_head.rs1 == 5'd0) ? '0 : r_shadow[w_head.rs1];
    assign w_expected = aluResult(w_head, w_rs1Val);

    itc_fifo #(.DEPTH(DEPTH)) u_fifo (
        .clk        (clk),
        .reset_n    (reset_n),
        .i_push     (w_enq),
        .i_pushData (w_newEntry),
        .i_pop      (w_pop),
        .o_head     (w_head),
        .o_full     (w_full),
        .o_empty    (w_empty),
        .o_count    (occupancy)
    );

    always_comb begin
        w_errCode = ERR_NONE;
        if (w_empty)                     w_errCode = ERR_UNDERFLOW;
        else if (w_head.rd != wb_rd)     w_errCode = ERR_RD;
        else if (w_expected != wb_data)  w_errCode = ERR_DATA;
    end

    // Shadow is updated from the prediction, never from the core, and survives reset.
    always_ff @(posedge clk) begin
        if (w_pop)
            r_shadow[w_head.rd] <= w_expected;
        else if (init_we && (init_addr != 5'd0))
            r_shadow[init_addr] <= init_data;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_mismatch <= 1'b0;
            r_errCode  <= ERR_NONE;
            r_passCnt  <= '0;
            r_errCnt   <= '0;
        end else if (w_commit) begin
            if (w_errCode == ERR_NONE) begin
                if (r_passCnt != '1) r_passCnt <= r_passCnt + 32'd1;
            end else begin
                if (r_errCnt != '1) r_errCnt <= r_errCnt + 32'd1;
            end
`ifdef ITC_STICKY_ERR_EN
            if ((w_errCode != ERR_NONE) && !r_mismatch) begin
                r_mismatch <= 1'b1;
                r_errCode  <= w_errCode;
            end
`else
            r_mismatch <= (w_errCode != ERR_NONE);
            r_errCode  <= w_errCode;
`endif
        end else begin
`ifndef ITC_STICKY_ERR_EN
            r_mismatch <= 1'b0;
`endif
        end
    end

    assign mismatch = r_mismatch;
    assign err_code = r_errCode;
    assign pass_cnt = r_passCnt;
    assign err_cnt  = r_errCnt;

endmodule
